// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer: state encoding and counter widths.
package run_seq_pkg;

   localparam int CNT_W_DEF = 32;
   localparam int DRAIN_W   = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } seq_state_t;

endpackage

// File: rtl/seq_match_flag.sv
// Sticky milestone flag: sets the cycle after a qualified count equals match, cleared by clr.
module seq_match_flag
   import run_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             qual,
   input  logic [CNT_W-1:0] count,
   input  logic [CNT_W-1:0] match,
   output logic             flag
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag <= 1'b0;
      end else if (clr) begin
         flag <= 1'b0;
      end else if (qual && (count == match)) begin
         flag <= 1'b1;
      end
   end

endmodule

// File: rtl/run_sequencer.sv
// Clear/run/pause/drain/done controller for the run counter; all outputs registered except busy_o.
// RUN_SEQ_AUTO_RESTART_EN makes DONE loop back to CLEAR and enables the completed-run counter.
module run_sequencer
   import run_seq_pkg::*;
#(
   parameter int          CNT_W        = CNT_W_DEF,
   parameter int unsigned DEF_LIMIT    = 100,
   parameter int          DRAIN_CYCLES = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             pause_i,
   input  logic             cfg_ld_i,
   input  logic [CNT_W-1:0] limit_i,
   input  logic [CNT_W-1:0] match0_i,
   input  logic [CNT_W-1:0] match1_i,
   output logic             en_o,
   output logic             clr_o,
   output logic [CNT_W-1:0] count_o,
   output logic             busy_o,
   output logic             hit0_o,
   output logic             hit1_o,
   output logic             abort_o,
   output logic             done_o,
   output logic [2:0]       state_o,
   output logic [15:0]      run_cnt_o
);

   seq_state_t         state, nxt;
   logic [CNT_W-1:0]   limit_q, match0_q, match1_q;
   logic [DRAIN_W-1:0] drain_cnt;
   logic               last_inc, abortable, qual, clr_flags;

   // count never passes limit, so count+1 cannot overflow here
   assign last_inc  = ((count_o + CNT_W'(1)) == limit_q);
   assign abortable = (state == S_CLEAR) || (state == S_RUN) ||
                      (state == S_PAUSE) || (state == S_DRAIN);
   assign qual      = (state == S_RUN) || (state == S_PAUSE);
   assign clr_flags = (nxt == S_CLEAR);
   assign busy_o    = (state != S_IDLE);
   assign state_o   = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE: begin
            if (start_i) nxt = S_CLEAR;
         end
         S_CLEAR: begin
            if (stop_i)                nxt = S_IDLE;
            else if (limit_q == '0)    nxt = S_DRAIN;
            else                       nxt = S_RUN;
         end
         S_RUN: begin
            if (stop_i)                nxt = S_IDLE;
            else if (last_inc)         nxt = S_DRAIN;
            else if (pause_i)          nxt = S_PAUSE;
         end
         S_PAUSE: begin
            if (stop_i)                nxt = S_IDLE;
            else if (!pause_i)         nxt = S_RUN;
         end
         S_DRAIN: begin
            if (stop_i)                nxt = S_IDLE;
            else if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) nxt = S_DONE;
         end
         S_DONE: begin
`ifdef RUN_SEQ_AUTO_RESTART_EN
            nxt = S_CLEAR;
`else
            nxt = S_IDLE;
`endif
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_o      <= 1'b0;
         clr_o     <= 1'b0;
         done_o    <= 1'b0;
         abort_o   <= 1'b0;
         count_o   <= '0;
         drain_cnt <= '0;
         limit_q   <= CNT_W'(DEF_LIMIT);
         match0_q  <= '1;
         match1_q  <= '1;
      end else begin
         en_o   <= (nxt == S_RUN);
         clr_o  <= (nxt == S_CLEAR);
         done_o <= (nxt == S_DONE);

         if ((state == S_IDLE) && cfg_ld_i) begin
            limit_q  <= limit_i;
            match0_q <= match0_i;
            match1_q <= match1_i;
         end

         // a stopped run keeps its count so it can be inspected from IDLE
         if (nxt == S_CLEAR) begin
            count_o <= '0;
         end else if ((state == S_RUN) && !stop_i) begin
            count_o <= count_o + CNT_W'(1);
         end

         if (nxt == S_CLEAR) begin
            abort_o <= 1'b0;
         end else if (abortable && stop_i) begin
            abort_o <= 1'b1;
         end

         if (state == S_DRAIN) begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
         end else begin
            drain_cnt <= '0;
         end
      end
   end

`ifdef RUN_SEQ_AUTO_RESTART_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_cnt_o <= '0;
      end else if ((state == S_DONE) && (run_cnt_o != 16'hFFFF)) begin
         run_cnt_o <= run_cnt_o + 16'd1;
      end
   end
`else
   assign run_cnt_o = '0;
`endif

   seq_match_flag #(.CNT_W(CNT_W)) u_hit0 (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_flags),
      .qual  (qual),
      .count (count_o),
      .match (match0_q),
      .flag  (hit0_o)
   );

   seq_match_flag #(.CNT_W(CNT_W)) u_hit1 (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_flags),
      .qual  (qual),
      .count (count_o),
      .match (match1_q),
      .flag  (hit1_o)
   );

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Controller that sequences a simulation-run counter datapath: clear, run for a programmed cycle count, pause, drain, then signal completion.
- Drives enable/clear to the counter, tracks two programmable milestone counts with sticky hit flags, and emits a one-cycle done pulse that the bench uses to end simulation.
- Sits between testbench stimulus and the counter/coverage logic in the top-level example.

Parameters:
- CNT_W, 32, width of run counter, limit and match values
- DEF_LIMIT, 100, run length loaded at reset
- DRAIN_CYCLES, 3, idle cycles inserted after limit is reached before done; range 1..15

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start_i  input  1  run request; sampled in IDLE only
- stop_i  input  1  abort request
- pause_i  input  1  level; holds the run while high
- cfg_ld_i  input  1  load limit/match values; IDLE only
- limit_i  input  CNT_W  run length
- match0_i  input  CNT_W  milestone 0 value
- match1_i  input  CNT_W  milestone 1 value
- en_o  output  1  counter enable to datapath
- clr_o  output  1  synchronous clear to datapath
- count_o  output  CNT_W  cycles run so far
- busy_o  output  1  high in any state except IDLE
- hit0_o  output  1  sticky: count reached match0
- hit1_o  output  1  sticky: count reached match1
- abort_o  output  1  sticky: last run was stopped
- done_o  output  1  one-cycle completion pulse
- state_o  output  3  current state encoding
- run_cnt_o  output  16  completed runs (feature only)

Behaviour:
- Reset values (immediate, async):
  - State IDLE.
  - limit = DEF_LIMIT; match0 = match1 = all-ones.
  - All outputs 0.
- States:
  - IDLE: start_i moves to CLEAR. cfg_ld_i captures limit_i, match0_i and match1_i. Same-cycle start and cfg_ld: the load takes effect first and the new run uses the new values.
  - CLEAR: exactly 1 cycle. clr_o=1, count_o to 0, hit0/hit1/abort cleared. Goes to RUN, or to DRAIN if limit==0.
  - RUN: en_o=1 and count_o increments every cycle. When count_o==limit-1 the increment lands on limit and the next state is DRAIN. count_o never exceeds limit and never wraps.
  - PAUSE: entered from RUN while pause_i=1. en_o=0, count_o held. Returns to RUN the cycle after pause_i falls.
  - DRAIN: en_o=0 for DRAIN_CYCLES cycles (internal 4-bit counter), then DONE.
  - DONE: done_o=1 for 1 cycle, then IDLE.
- Priority in RUN/PAUSE: stop_i > limit reached > pause_i.
  - stop_i in CLEAR/RUN/PAUSE/DRAIN: next state IDLE, abort_o=1, no done pulse, count_o held for inspection.
  - stop_i in DONE is ignored; the done pulse completes.
- Ignored inputs:
  - start_i outside IDLE is dropped, not queued.
  - cfg_ld_i outside IDLE is ignored.
- Milestone hit flags:
  - hitN_o is set in the cycle after count_o==matchN while in RUN or PAUSE. The comparison uses the registered count.
  - The flag remains set until the next CLEAR.
  - A match value greater than limit is never hit.
- Outputs are registered except busy_o, which is decoded from state.
- State encoding on state_o: IDLE=0, CLEAR=1, RUN=2, PAUSE=3, DRAIN=4, DONE=5.
- Reset asserted mid-run returns everything to reset values asynchronously. There is no done pulse, and the limit reverts to DEF_LIMIT.

Optional Feature:
- Macro RUN_SEQ_AUTO_RESTART_EN.
- Defined:
  - DONE goes to CLEAR instead of IDLE, so runs repeat back-to-back until stop_i.
  - run_cnt_o increments on each DONE and saturates at 16'hFFFF.
  - run_cnt_o clears on reset only.
- Undefined:
  - DONE goes to IDLE.
  - run_cnt_o is tied to 0.

Decomposition:
- Package run_seq_pkg holds:
  - state enum typedef (3-bit, encodings above)
  - default CNT_W constant
  - DRAIN counter width constant
- One sub-module, seq_match_flag: registered equality compare plus sticky flag with clear and qualify inputs, CNT_W parameter. Instantiated twice, for hit0 and hit1.

Test Plan:
- Reset defaults, start: count_o runs 1..100 with en_o high 100 cycles; DRAIN 3 cycles; done_o pulses once; total 105 cycles from start to IDLE.
- cfg_ld with limit=10, match0=5, match1=20, then start: hit0_o set at count 6 visible cycle, hit1_o stays 0, done_o after count_o=10.
- pause_i high 4 cycles at count 7 (limit 10): count_o holds 7, en_o=0 for 4 cycles, run resumes, done 4 cycles later than unpaused.
- stop_i at count 3: IDLE next cycle, abort_o=1, done_o never pulses, count_o=3. Next start clears abort_o and count.
- limit=0: CLEAR, then DRAIN, then DONE; en_o never asserts; done_o pulses 5 cycles after start.
- reset pulsed during RUN at count 40 (async, between edges): outputs 0 immediately, limit back to 100. With RUN_SEQ_AUTO_RESTART_EN, 3 back-to-back runs give run_cnt_o=3.
